// File: rtl/round_shift_pkg.sv
// rtl/round_shift_pkg.sv - shared constants and width helpers for the round/shift/saturate pipe
package round_shift_pkg;

    typedef enum logic [0:0] {
        RND_HALF_EVEN = 1'b0,
        RND_TRUNC     = 1'b1
    } round_mode_e;

    // Unbiased rounding keeps the long-run mean of accumulator outputs unchanged
    localparam round_mode_e ROUND_MODE = RND_HALF_EVEN;

    // One extra bit so max-positive plus a round-up cannot wrap
    function automatic int s1_width(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int sat_max(input int out_width);
        return (1 << (out_width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int out_width);
        return -(1 << (out_width - 1));
    endfunction

endpackage

// File: rtl/round_shift_var.sv
// rtl/round_shift_var.sv - combinational per-channel variable arithmetic right shift with half-to-even rounding
module round_shift_var
    import round_shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic signed [DATA_WIDTH-1:0]           x,
    input  logic        [SHIFT_WIDTH-1:0]          shift_amount,
    output logic signed [s1_width(DATA_WIDTH)-1:0] r
);

    localparam int SIW = $clog2(DATA_WIDTH);
    localparam int RW  = s1_width(DATA_WIDTH);

    logic        [SIW-1:0]        s_eff;
    logic signed [DATA_WIDTH-1:0] shifted;
    logic        [DATA_WIDTH-1:0] sticky_mask;
    logic                         half_bit;
    logic                         sticky;
    logic                         round_bit;

    // Clamp the shift, shift arithmetically, then add the half-to-even round bit at full width
    always_comb begin
        if (32'(shift_amount) > 32'(DATA_WIDTH - 1)) begin
            s_eff = SIW'(DATA_WIDTH - 1);
        end else begin
            s_eff = SIW'(shift_amount);
        end
        shifted     = x >>> s_eff;
        half_bit    = 1'b0;
        sticky_mask = '0;
        sticky      = 1'b0;
        if (s_eff != '0) begin
            half_bit    = x[s_eff - SIW'(1)];
            sticky_mask = (DATA_WIDTH'(1) << (s_eff - SIW'(1))) - DATA_WIDTH'(1);
            sticky      = |(x & sticky_mask);
        end
        // Exact half rounds up only when the kept LSB is odd
        round_bit = (ROUND_MODE == RND_HALF_EVEN) ? (half_bit & (shifted[0] | sticky)) : 1'b0;
        r         = {shifted[DATA_WIDTH-1], shifted} + RW'(round_bit);
    end

endmodule

// File: rtl/round_shift_pipe.sv
// rtl/round_shift_pipe.sv - 2-stage multi-channel round/shift/saturate pipe; optional counter via ROUND_SHIFT_SAT_CNT_EN
module round_shift_pipe
    import round_shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int NUM_CH      = 2,
    parameter int SHIFT_WIDTH = 4
`ifdef ROUND_SHIFT_SAT_CNT_EN
    ,
    parameter int CNT_WIDTH   = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  data_in,
    input  logic [SHIFT_WIDTH-1:0]        shift_amount,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*OUT_WIDTH-1:0]   data_out,
    output logic [NUM_CH-1:0]             sat_flag
`ifdef ROUND_SHIFT_SAT_CNT_EN
    ,
    input  logic                          sat_cnt_clear,
    output logic [CNT_WIDTH-1:0]          sat_count
`endif
);

    localparam int RW = s1_width(DATA_WIDTH);
    localparam logic signed [RW-1:0] CLAMP_HI = RW'(sat_max(OUT_WIDTH));
    localparam logic signed [RW-1:0] CLAMP_LO = RW'(sat_min(OUT_WIDTH));

    logic                       ready_en;
    logic                       s1_valid;
    logic [NUM_CH-1:0][RW-1:0]  s1_r;
    logic [NUM_CH-1:0][RW-1:0]  r_comb;
    logic                       s2_ready;
    logic                       s1_ready;
    logic                       s1_load;
    logic                       s2_load;
    logic [NUM_CH*OUT_WIDTH-1:0] clamp_data;
    logic [NUM_CH-1:0]          clamp_sat;

    // A stage accepts when empty or when its content leaves in the same cycle
    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = ready_en && s1_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && s2_ready;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        round_shift_var #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_round_shift_var (
            .x            (data_in[ch*DATA_WIDTH +: DATA_WIDTH]),
            .shift_amount (shift_amount),
            .r            (r_comb[ch])
        );
    end

    // Clamp each stage-1 result into the output range and flag clamped channels
    always_comb begin
        clamp_data = '0;
        clamp_sat  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($signed(s1_r[ch]) > CLAMP_HI) begin
                clamp_data[ch*OUT_WIDTH +: OUT_WIDTH] = CLAMP_HI[OUT_WIDTH-1:0];
                clamp_sat[ch]                         = 1'b1;
            end else if ($signed(s1_r[ch]) < CLAMP_LO) begin
                clamp_data[ch*OUT_WIDTH +: OUT_WIDTH] = CLAMP_LO[OUT_WIDTH-1:0];
                clamp_sat[ch]                         = 1'b1;
            end else begin
                clamp_data[ch*OUT_WIDTH +: OUT_WIDTH] = s1_r[ch][OUT_WIDTH-1:0];
            end
        end
    end

    // Hold off input acceptance until the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Stage 1: register the rounded, shifted samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= s1_load || (s1_valid && !s2_load);
            if (s1_load) begin
                s1_r <= r_comb;
            end
        end
    end

    // Stage 2: register the saturated output beat, held stable while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_flag  <= '0;
        end else begin
            out_valid <= s2_load || (out_valid && !out_ready);
            if (s2_load) begin
                data_out <= clamp_data;
                sat_flag <= clamp_sat;
            end
        end
    end

`ifdef ROUND_SHIFT_SAT_CNT_EN
    // Count transferred beats with any channel saturated; sticks at all-ones, clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_cnt_clear) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && (|sat_flag) && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_WIDTH'(1);
        end
    end
`else
    // Saturation counter not built in this configuration
`endif

endmodule

// File: tb/tb_round_shift_pipe.sv
// tb/tb_round_shift_pipe.sv - randomized and directed self-checking bench for round_shift_pipe
module tb_round_shift_pipe;

    localparam int DW  = 16;
    localparam int OW  = 8;
    localparam int NCH = 2;
    localparam int SW  = 4;
    localparam int CW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [NCH*DW-1:0]   data_in = '0;
    logic [SW-1:0]       shift_amount = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [NCH*OW-1:0]   data_out;
    logic [NCH-1:0]      sat_flag;
`ifdef ROUND_SHIFT_SAT_CNT_EN
    logic                sat_cnt_clear = 1'b0;
    logic [CW-1:0]       sat_count;
`endif

    logic                in_valid5 = 1'b0;
    logic                in_ready5;
    logic [NCH*DW-1:0]   data_in5 = '0;
    logic [4:0]          shift5 = '0;
    logic                out_valid5;
    logic                out_ready5 = 1'b0;
    logic [NCH*OW-1:0]   data_out5;
    logic [NCH-1:0]      sat_flag5;
`ifdef ROUND_SHIFT_SAT_CNT_EN
    logic [CW-1:0]       sat_count5;
`endif

    always #5 clk = ~clk;

    round_shift_pipe #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_CH(NCH), .SHIFT_WIDTH(SW)
`ifdef ROUND_SHIFT_SAT_CNT_EN
        , .CNT_WIDTH(CW)
`endif
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_amount(shift_amount), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .sat_flag(sat_flag)
`ifdef ROUND_SHIFT_SAT_CNT_EN
        , .sat_cnt_clear(sat_cnt_clear), .sat_count(sat_count)
`endif
    );

    round_shift_pipe #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_CH(NCH), .SHIFT_WIDTH(5)
`ifdef ROUND_SHIFT_SAT_CNT_EN
        , .CNT_WIDTH(CW)
`endif
    ) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .data_in(data_in5), .shift_amount(shift5), .out_valid(out_valid5),
        .out_ready(out_ready5), .data_out(data_out5), .sat_flag(sat_flag5)
`ifdef ROUND_SHIFT_SAT_CNT_EN
        , .sat_cnt_clear(1'b0), .sat_count(sat_count5)
`endif
    );

    int nvec = 0;
    int nfail = 0;
    int n_acc = 0;
    int n_pop = 0;
    int exp_cnt = 0;
    int lat;
    int base;
    bit popped;
    logic [NCH*OW-1:0] pop_data;
    logic [NCH-1:0]    pop_sat;
    logic [NCH*OW-1:0] exp_d_q[$];
    logic [NCH-1:0]    exp_s_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued x / 2^s rounded half-to-even, then clamped to the output range
    function automatic void ref_beat(input logic [NCH*DW-1:0] din, input int sh,
                                     output logic [NCH*OW-1:0] d, output logic [NCH-1:0] s);
        longint x, p, q, rem;
        int se;
        d = '0;
        s = '0;
        se = (sh > DW - 1) ? DW - 1 : sh;
        p = longint'(1) << se;
        for (int ch = 0; ch < NCH; ch++) begin
            x = longint'($signed(din[ch*DW +: DW]));
            if (x >= 0) q = x / p;
            else        q = -((-x + p - 1) / p);
            rem = x - q * p;
            if (2 * rem > p) q = q + 1;
            else if ((2 * rem == p) && ((q & 1) != 0)) q = q + 1;
            if (q > 127) begin
                q = 127;
                s[ch] = 1'b1;
            end else if (q < -128) begin
                q = -128;
                s[ch] = 1'b1;
            end
            d[ch*OW +: OW] = q[OW-1:0];
        end
    endfunction

    task automatic tick();
        logic [NCH*OW-1:0] d;
        logic [NCH-1:0]    s;
        logic [NCH-1:0]    es;
        bit                pop_sat_any;
        @(negedge clk);
        popped = 0;
        pop_sat_any = 0;
        if (in_valid && in_ready) begin
            ref_beat(data_in, int'(shift_amount), d, s);
            exp_d_q.push_back(d);
            exp_s_q.push_back(s);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            check("queue_nonempty_at_pop", 64'(exp_d_q.size() != 0), 64'(1));
            if (exp_d_q.size() != 0) begin
                es = exp_s_q.pop_front();
                check("data_out", 64'(data_out), 64'(exp_d_q.pop_front()));
                check("sat_flag", 64'(sat_flag), 64'(es));
                pop_sat_any = |es;
            end
            popped   = 1;
            pop_data = data_out;
            pop_sat  = sat_flag;
            n_pop++;
        end
`ifdef ROUND_SHIFT_SAT_CNT_EN
        if (sat_cnt_clear) exp_cnt = 0;
        else if (pop_sat_any && exp_cnt < (1 << CW) - 1) exp_cnt = exp_cnt + 1;
`endif
        @(posedge clk);
        #1;
`ifdef ROUND_SHIFT_SAT_CNT_EN
        check("sat_count", 64'(sat_count), 64'(exp_cnt));
`endif
    endtask

    task automatic single(input logic [15:0] x0, input int sh, input logic [7:0] e0,
                          input logic e_sat, input string tag, output int latency);
        int a0;
        a0 = n_acc;
        in_valid = 1'b1;
        data_in = {16'($urandom), x0};
        shift_amount = SW'(sh);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && n_acc == a0; i++) tick();
        in_valid = 1'b0;
        latency = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            latency++;
            if (popped) break;
        end
        check({tag, "_arrived"}, 64'(popped), 64'(1));
        check(tag, 64'(pop_data[7:0]), 64'(e0));
        check({tag, "_sat"}, 64'(pop_sat[0]), 64'(e_sat));
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_sat_flag", 64'(sat_flag), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 64'(in_ready), 64'(1));

        // Half-to-even at shift 2, both signs; first beat also measures latency
        single(16'd6, 2, 8'd2, 1'b0, "r_6_s2", lat);
        check("latency", 64'(lat), 64'(2));
        single(16'd10, 2, 8'd2, 1'b0, "r_10_s2", lat);
        single(16'd11, 2, 8'd3, 1'b0, "r_11_s2", lat);
        single(-16'sd6, 2, 8'hFE, 1'b0, "r_m6_s2", lat);
        single(-16'sd10, 2, 8'hFE, 1'b0, "r_m10_s2", lat);

        // Saturation boundaries
        single(16'd100, 0, 8'd100, 1'b0, "r_100_s0", lat);
        single(16'd200, 0, 8'd127, 1'b1, "r_200_s0", lat);
        single(-16'sd129, 0, 8'h80, 1'b1, "r_m129_s0", lat);
        single(16'h8000, 8, 8'h80, 1'b0, "r_min_s8", lat);
        single(16'h7FFF, 15, 8'd1, 1'b0, "r_max_s15", lat);
        single(16'h7FFF, 4, 8'd127, 1'b1, "r_max_s4", lat);

        // Wider shift port with an amount beyond the sample width clamps the shift
        in_valid5 = 1'b1;
        data_in5 = {16'h7FFF, 16'h7FFF};
        shift5 = 5'd20;
        tick();
        in_valid5 = 1'b0;
        tick();
        check("w5_out_valid", 64'(out_valid5), 64'(1));
        check("w5_data_out", 64'(data_out5), 64'(16'h0101));
        check("w5_sat_flag", 64'(sat_flag5), 64'(0));
        out_ready5 = 1'b1;

        // Backpressure: pipe fills after two beats, then streams at one per cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        base = n_acc;
        for (int i = 0; i < 5; i++) begin
            data_in = $urandom;
            shift_amount = SW'($urandom_range(0, 15));
            tick();
        end
        check("bp_accepted", 64'(n_acc - base), 64'(2));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        base = n_acc;
        for (int i = 0; i < 20; i++) begin
            data_in = $urandom;
            shift_amount = SW'($urandom_range(0, 15));
            tick();
        end
        check("stream_accepted", 64'(n_acc - base), 64'(20));
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("stream_drained", 64'(exp_d_q.size()), 64'(0));

        // Random traffic with random stalls
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            data_in = $urandom;
            shift_amount = SW'($urandom_range(0, 15));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rand_drained", 64'(exp_d_q.size()), 64'(0));
        check("rand_acc_eq_pop", 64'(n_acc), 64'(n_pop));

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = $urandom;
            tick();
        end
        check("full_out_valid", 64'(out_valid), 64'(1));
        check("full_in_ready", 64'(in_ready), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_data_out", 64'(data_out), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(0));
        exp_d_q.delete();
        exp_s_q.delete();
        exp_cnt = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready_low", 64'(in_ready), 64'(0));
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        single(16'd11, 2, 8'd3, 1'b0, "post_rst_beat", lat);
        check("post_rst_latency", 64'(lat), 64'(2));

`ifdef ROUND_SHIFT_SAT_CNT_EN
        // Saturation counter: count, clear-wins-over-increment, stick at all-ones
        for (int i = 0; i < 3; i++) single(16'd200, 0, 8'd127, 1'b1, "cnt_beat", lat);
        check("cnt_three", 64'(sat_count), 64'(3));
        in_valid = 1'b1;
        out_ready = 1'b0;
        data_in = {16'd300, 16'd300};
        shift_amount = '0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        sat_cnt_clear = 1'b1;
        tick();
        sat_cnt_clear = 1'b0;
        check("cnt_clear_pop", 64'(sat_count), 64'(0));
        for (int i = 0; i < 5; i++) single(-16'sd300, 0, 8'h80, 1'b1, "cnt_sat_beat", lat);
        check("cnt_saturated", 64'(sat_count), 64'(3));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
